// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble/SFD insertion, zero padding, CRC-32 FCS and
// inter-packet gap, driving RMII TX_EN/TXD one dibit per clk.
module eth_tx_framer #(
   parameter int unsigned PREAMBLE_BYTES = 7,
   parameter int unsigned MIN_DATA_LEN   = 60,
   parameter int unsigned IPG_BYTES      = 12
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inclk,
   input  logic [7:0] in,
   input  logic       in_last,
   output logic       in_rdy,
   output logic       busy,
   output logic       eth_txen,
   output logic [1:0] eth_txd,
   output logic       frame_done,
   output logic       underrun
);

   localparam logic [31:0] POLY     = 32'hEDB88320;
   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES * 4 - 1);
   localparam logic [15:0] IPG_LAST = 16'(IPG_BYTES * 4 - 1);
   localparam logic [10:0] MIN_LEN  = 11'(MIN_DATA_LEN);

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IPG
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] tcnt;
   logic [1:0]  dib;
   logic        buf_valid, buf_last, last_acc;
   logic [7:0]  buf_data, cur_q, cur_byte;
   logic        cur_last;
   logic [10:0] byte_cnt;
   logic [31:0] crc, fcs;
   logic [1:0]  data_dib, fcs_dib;
   logic        accept;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] r;
      r = c;
      for (int unsigned i = 0; i < 2; i++) begin
         r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? POLY : '0);
      end
      return r;
   endfunction

   assign dib    = tcnt[1:0];
   assign accept = inclk & in_rdy;
   assign fcs    = ~crc;

   // The first dibit of a byte is taken straight from the holding buffer,
   // which is released on that same cycle.
   always_comb begin
      cur_byte = '0;
      if (state == DATA) begin
         cur_byte = (dib == 2'd0) ? buf_data : cur_q;
      end
      data_dib = cur_byte[{dib, 1'b0} +: 2];
      fcs_dib  = fcs[{tcnt[3:0], 1'b0} +: 2];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (accept) state_nxt = PREAMBLE;
         PREAMBLE: if (tcnt == PRE_LAST) state_nxt = SFD;
         SFD:      if (tcnt == 16'd3) state_nxt = DATA;
         DATA: begin
            if (dib == 2'd3) begin
               if (cur_last) begin
                  state_nxt = (byte_cnt < MIN_LEN) ? PAD : FCS;
               end else if (!buf_valid) begin
                  state_nxt = IPG;
               end
            end
         end
         PAD:      if (dib == 2'd3 && byte_cnt == MIN_LEN) state_nxt = FCS;
         FCS:      if (tcnt == 16'd15) state_nxt = IPG;
         IPG:      if (tcnt == IPG_LAST) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      eth_txen = 1'b0;
      eth_txd  = 2'b00;
      in_rdy   = reset_n & ~buf_valid & ~last_acc &
                 (state inside {IDLE, PREAMBLE, SFD, DATA});
      unique case (state)
         PREAMBLE: begin
            eth_txen = 1'b1;
            eth_txd  = 2'b01;
         end
         SFD: begin
            eth_txen = 1'b1;
            eth_txd  = (tcnt[1:0] == 2'd3) ? 2'b11 : 2'b01;
         end
         DATA, PAD: begin
            eth_txen = 1'b1;
            eth_txd  = data_dib;
         end
         FCS: begin
            eth_txen = 1'b1;
            eth_txd  = fcs_dib;
         end
         default: begin
            eth_txen = 1'b0;
            eth_txd  = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tcnt       <= '0;
         buf_valid  <= 1'b0;
         buf_last   <= 1'b0;
         buf_data   <= '0;
         last_acc   <= 1'b0;
         cur_q      <= '0;
         cur_last   <= 1'b0;
         byte_cnt   <= '0;
         crc        <= '1;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         tcnt       <= (state_nxt != state) ? '0 : tcnt + 16'd1;
         frame_done <= (state == FCS)  && (state_nxt == IPG);
         underrun   <= (state == DATA) && (state_nxt == IPG);

         if (state == DATA && dib == 2'd0) begin
            buf_valid <= 1'b0;
            cur_q     <= buf_data;
            cur_last  <= buf_last;
            byte_cnt  <= byte_cnt + 11'd1;
         end
         if (state == PAD && dib == 2'd0) begin
            byte_cnt <= byte_cnt + 11'd1;
         end
         if (accept) begin
            buf_valid <= 1'b1;
            buf_data  <= in;
            buf_last  <= in_last;
         end

         if (accept && in_last) begin
            last_acc <= 1'b1;
         end else if (state == IPG) begin
            last_acc <= 1'b0;
         end

         if (state == SFD) begin
            byte_cnt <= '0;
            crc      <= '1;
         end else if (state == DATA || state == PAD) begin
            crc <= crc_step(crc, data_dib);
         end
      end
   end

endmodule
